// File: rtl/priority_encoder_rr.sv
// Registered N-bit priority encoder with valid/ready handshake.
// MODE=0: highest set index wins. MODE=1: round-robin, priority rotates past the last winner.
module priority_encoder_rr #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] xin,
    output logic [N-1:0] gnt,
    output logic         v,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] ptr;
    logic [W-1:0] win;
    logic         hit;
    int           t;

    // Walk the search order ptr-1, ptr-2, ... backwards so the earliest hit is the
    // last one assigned. The wrap is done in int arithmetic with an explicit compare,
    // so a non-power-of-two N never yields an index above N-1.
    always_comb begin
        win = '0;
        hit = 1'b0;
        t   = 0;
        for (int j = N - 1; j >= 0; j--) begin
            t = int'(ptr) - 1 - j;
            if (t < 0)
                t = t + N;
            if (d[t[W-1:0]]) begin
                win = t[W-1:0];
                hit = 1'b1;
            end
        end
    end

    assign in_ready = !rst && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            xin       <= '0;
            gnt       <= '0;
            v         <= 1'b0;
            ptr       <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            xin       <= win;
            gnt       <= hit ? (N'(1) << win) : '0;
            v         <= hit;
            if (MODE == 1 && hit)
                ptr <= win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: three instances (N=8 fixed, N=8 round-robin, N=5 round-robin)
// checked every cycle against a search-order model, plus directed literal expectations.
module tb_priority_encoder_rr;
    localparam int NN [3] = '{8, 8, 5};
    localparam int MD [3] = '{0, 1, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d    [3];
    logic       iv   [3];
    logic       ordy [3];
    logic       ir   [3];
    logic       ov   [3];
    logic       vv   [3];
    logic [2:0] xin  [3];
    logic [7:0] gnt0, gnt1;
    logic [4:0] gnt2;
    logic [7:0] g    [3];

    int   nvec = 0;
    int   nerr = 0;
    bit   chk_en = 1'b0;

    int         m_ptr [3];
    int         m_x   [3];
    logic [7:0] m_g   [3];
    bit         m_v   [3];
    bit         m_ov  [3];

    always #5 clk = ~clk;

    always_comb begin
        g[0] = gnt0;
        g[1] = gnt1;
        g[2] = {3'b000, gnt2};
    end

    priority_encoder_rr #(.N(8), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .d(d[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .xin(xin[0]), .gnt(gnt0), .v(vv[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
    priority_encoder_rr #(.N(8), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .d(d[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .xin(xin[1]), .gnt(gnt1), .v(vv[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
    priority_encoder_rr #(.N(5), .MODE(1)) u2 (
        .clk(clk), .rst(rst), .d(d[2][4:0]), .in_valid(iv[2]), .in_ready(ir[2]),
        .xin(xin[2]), .gnt(gnt2), .v(vv[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

    // First set bit in the order ptr-1, ptr-2, ... (mod n); -1 when none.
    function automatic int pick(int n, int p, logic [7:0] req);
        for (int k = 1; k <= n; k++) begin
            int i;
            i = ((p - k) % n + n) % n;
            if (req[i])
                return i;
        end
        return -1;
    endfunction

    function automatic void chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin : model
        int w;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_ov[k] = 0; m_x[k] = 0; m_g[k] = '0; m_v[k] = 0; m_ptr[k] = 0;
            end else if (iv[k] && (!m_ov[k] || ordy[k])) begin
                w = pick(NN[k], m_ptr[k], d[k]);
                m_ov[k] = 1;
                m_v[k]  = (w >= 0);
                m_x[k]  = m_v[k] ? w : 0;
                m_g[k]  = m_v[k] ? (8'd1 << w) : 8'd0;
                if (MD[k] == 1 && m_v[k])
                    m_ptr[k] = w;
            end else if (ordy[k]) begin
                m_ov[k] = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("out_valid", k, ov[k], m_ov[k]);
                chk("in_ready", k, ir[k], !rst && (!m_ov[k] || ordy[k]));
                if (m_ov[k]) begin
                    chk("xin", k, xin[k], m_x[k]);
                    chk("gnt", k, g[k], m_g[k]);
                    chk("v", k, vv[k], m_v[k]);
                end
            end
            chk("xin_range", 2, (xin[2] <= 3'd4), 1);
        end
    end

    task automatic drive(int k, logic [7:0] dd, logic ivv, logic r);
        @(negedge clk);
        d[k] = dd; iv[k] = ivv; ordy[k] = r;
    endtask

    task automatic lit(string nm, int k, int ex, logic [7:0] eg, logic ev, logic eov);
        @(posedge clk);
        #2;
        chk({nm, "_ov"}, k, ov[k], eov);
        chk({nm, "_xin"}, k, xin[k], ex);
        chk({nm, "_gnt"}, k, g[k], eg);
        chk({nm, "_v"}, k, vv[k], ev);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            d[k] = '0; iv[k] = 1'b0; ordy[k] = 1'b1;
        end
        // reset held two cycles
        @(posedge clk);
        chk_en = 1'b1;
        lit("rst", 0, 0, 8'h00, 0, 0);
        chk("rst_ir", 0, ir[0], 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rel_ir", 0, ir[0], 1);

        // fixed priority, back-to-back
        drive(0, 8'h80, 1, 1); lit("fp", 0, 7, 8'h80, 1, 1);
        drive(0, 8'h16, 1, 1); lit("fp", 0, 4, 8'h10, 1, 1);
        drive(0, 8'h01, 1, 1); lit("fp", 0, 0, 8'h01, 1, 1);
        drive(0, 8'h00, 1, 1); lit("fp_empty", 0, 0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 1); lit("fp_drain", 0, 0, 8'h00, 0, 0);

        // round-robin rotation on all-ones
        for (int i = 0; i < 9; i++) begin
            int ex;
            ex = (i == 8) ? 7 : 7 - i;
            drive(1, 8'hFF, 1, 1);
            lit("rr_ff", 1, ex, 8'd1 << ex, 1, 1);
        end
        drive(1, 8'h08, 1, 1); lit("rr_p3", 1, 3, 8'h08, 1, 1);
        drive(1, 8'h08, 1, 1); lit("rr_self", 1, 3, 8'h08, 1, 1);
        drive(1, 8'h84, 1, 1); lit("rr_wrap", 1, 2, 8'h04, 1, 1);
        drive(1, 8'h00, 0, 1);

        // back-pressure then simultaneous consume and capture
        drive(0, 8'h40, 1, 1); lit("bp_cap", 0, 6, 8'h40, 1, 1);
        repeat (3) begin
            drive(0, 8'h00, 0, 0); lit("bp_hold", 0, 6, 8'h40, 1, 1);
            chk("bp_ir", 0, ir[0], 0);
        end
        drive(0, 8'h02, 1, 1); lit("bp_swap", 0, 1, 8'h02, 1, 1);
        drive(0, 8'h00, 0, 1);

        // N=5 wrap
        for (int i = 0; i < 4; i++) begin
            drive(2, 8'h11, 1, 1);
            lit("n5", 2, (i % 2 == 0) ? 4 : 0, (i % 2 == 0) ? 8'h10 : 8'h01, 1, 1);
        end
        drive(2, 8'h00, 0, 1);

        // reset mid-operation with a pending result and ptr=5
        drive(1, 8'h20, 1, 0); lit("mid", 1, 5, 8'h20, 1, 1);
        @(negedge clk);
        rst = 1'b1; iv[1] = 1'b0;
        lit("mid_rst", 1, 0, 8'h00, 0, 0);
        @(negedge clk);
        rst = 1'b0; d[1] = 8'hFF; iv[1] = 1'b1; ordy[1] = 1'b1;
        lit("mid_after", 1, 7, 8'h80, 1, 1);
        drive(1, 8'h00, 0, 1);

        // randomized traffic
        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 3; k++) begin
                d[k]    = 8'($urandom & $urandom);
                if ($urandom_range(0, 7) == 0)
                    d[k] = 8'h00;
                iv[k]   = ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
